// File: rtl/sonar_pkg.sv
// Shared constants and FSM encoding for the SONAR hydrophone ADC capture path.
package sonar_pkg;

    localparam int SONAR_ADC_WIDTH = 14;
    localparam int SONAR_NUM_CH    = 4;

    // Deserializer FSM: IDLE waits for a framed bit 0, SHIFT has a word in progress.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sonar_state_e;

endpackage

// File: rtl/sonar_shift_lane.sv
// One serial lane: shift register with shift enable and a synchronous restart
// that loads the current bit as bit 0 of a fresh word.
module sonar_shift_lane #(
    parameter int WIDTH     = 14,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             restart,
    input  logic             din,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] restart_val;

    // The word as it will look after this cycle's bit is shifted in; the top
    // level captures it directly on the completing edge.
    generate
        if (MSB_FIRST) begin : g_msb
            always_comb word = {sr_reg[WIDTH-2:0], din};
            always_comb restart_val = {{(WIDTH-1){1'b0}}, din};
        end else begin : g_lsb
            always_comb word = {din, sr_reg[WIDTH-1:1]};
            always_comb restart_val = {din, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    // Restart takes priority so a re-framed word discards the partial contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_reg <= '0;
        end else if (restart) begin
            sr_reg <= restart_val;
        end else if (shift_en) begin
            sr_reg <= word;
        end
    end

endmodule

// File: rtl/sonar_serial_deserializer.sv
// Multi-lane serial-to-parallel deserializer: framing FSM, bit counter,
// held output register with valid/ready handshake and sticky error flags.
module sonar_serial_deserializer
    import sonar_pkg::*;
#(
    parameter int WIDTH      = SONAR_ADC_WIDTH,
    parameter int NUM_CH     = SONAR_NUM_CH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    frame_start,
    input  logic [NUM_CH-1:0]       d,
    input  logic                    out_ready,
    input  logic                    clear_err,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun,
    output logic                    frame_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    sonar_state_e state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [NUM_CH*WIDTH-1:0] out_data_reg;
    logic [NUM_CH*WIDTH-1:0] lane_words;
    logic out_valid_reg, overrun_reg, frame_err_reg;
    logic shift_en, restart, complete, frame_set;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            sonar_shift_lane #(
                .WIDTH     (WIDTH),
                .MSB_FIRST (MSB_FIRST)
            ) u_lane (
                .clk      (clk),
                .reset    (reset),
                .shift_en (shift_en),
                .restart  (restart),
                .din      (d[gi]),
                .word     (lane_words[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

    // State and bit counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Next state, count and lane controls; frame_start always re-frames.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shift_en   = 1'b0;
        restart    = 1'b0;
        complete   = 1'b0;
        frame_set  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && frame_start) begin
                    restart    = 1'b1;
                    count_next = ONE;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    if (frame_start) begin
                        restart    = 1'b1;
                        frame_set  = 1'b1;
                        count_next = ONE;
                    end else if (count_reg == LAST_BIT) begin
                        shift_en   = 1'b1;
                        complete   = 1'b1;
                        count_next = '0;
                        state_next = CONTINUOUS ? SHIFT : IDLE;
                    end else begin
                        shift_en   = 1'b1;
                        count_next = count_reg + ONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output register: a completed word loads only when the slot is free or
    // being drained this cycle; otherwise the held word stays and the new one is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else if (complete && (!out_valid_reg || out_ready)) begin
            out_data_reg  <= lane_words;
            out_valid_reg <= 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Sticky error flags; a set event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (complete && out_valid_reg && !out_ready) begin
                overrun_reg <= 1'b1;
            end else if (clear_err) begin
                overrun_reg <= 1'b0;
            end
            if (frame_set) begin
                frame_err_reg <= 1'b1;
            end else if (clear_err) begin
                frame_err_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg == SHIFT);
    assign overrun   = overrun_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_sonar_serial_deserializer.sv
// Directed bench: three deserializer variants share one stimulus stream;
// each directed step checks the variant it targets.
module tb_sonar_serial_deserializer;

    localparam int W = 14;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic frame_start = 1'b0;
    logic out_ready = 1'b0;
    logic clear_err = 1'b0;
    logic [1:0] d = 2'b00;

    logic [2*W-1:0] a_data, b_data, c_data;
    logic a_valid, a_busy, a_ovr, a_ferr;
    logic b_valid, b_busy, b_ovr, b_ferr;
    logic c_valid, c_busy, c_ovr, c_ferr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // A: MSB-first, one word per frame
    sonar_serial_deserializer #(.WIDTH(W), .NUM_CH(2), .MSB_FIRST(1'b1), .CONTINUOUS(1'b0)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start), .d(d),
        .out_ready(out_ready), .clear_err(clear_err), .out_data(a_data), .out_valid(a_valid),
        .busy(a_busy), .overrun(a_ovr), .frame_err(a_ferr));

    // B: MSB-first, continuous framing
    sonar_serial_deserializer #(.WIDTH(W), .NUM_CH(2), .MSB_FIRST(1'b1), .CONTINUOUS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start), .d(d),
        .out_ready(out_ready), .clear_err(clear_err), .out_data(b_data), .out_valid(b_valid),
        .busy(b_busy), .overrun(b_ovr), .frame_err(b_ferr));

    // C: LSB-first
    sonar_serial_deserializer #(.WIDTH(W), .NUM_CH(2), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start), .d(d),
        .out_ready(out_ready), .clear_err(clear_err), .out_data(c_data), .out_valid(c_valid),
        .busy(c_busy), .overrun(c_ovr), .frame_err(c_ferr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, return 1 time unit after the rising edge.
    task automatic step(input logic en, input logic fs, input logic [1:0] dv, input logic clr);
        @(negedge clk);
        enable      = en;
        frame_start = fs;
        d           = dv;
        clear_err   = clr;
        @(posedge clk);
        #1;
    endtask

    // Send bits first..last of (w1,w0) MSB-first; frame_start on the first bit if fs.
    task automatic send_bits(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic fs,
                             input int first, input int last, input logic clr_last);
        for (int k = first; k <= last; k++) begin
            step(1'b1, fs && (k == first), {w1[W-1-k], w0[W-1-k]}, clr_last && (k == last));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        enable = 1'b0; frame_start = 1'b0; clear_err = 1'b0; out_ready = 1'b0; d = 2'b00;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_data", 32'(a_data), 32'h0);
        chk("rst_valid", 32'(a_valid), 32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_ovr", 32'(a_ovr), 32'h0);
        chk("rst_ferr", 32'(a_ferr), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 1: contiguous word, MSB-first
        send_bits(14'h2A5B, 14'h1234, 1'b1, 0, 12, 1'b0);
        chk("t1_busy_mid", 32'(a_busy), 32'h1);
        chk("t1_valid_early", 32'(a_valid), 32'h0);
        send_bits(14'h2A5B, 14'h1234, 1'b0, 13, 13, 1'b0);
        chk("t1_valid", 32'(a_valid), 32'h1);
        chk("t1_data", 32'(a_data), 32'({14'h1234, 14'h2A5B}));
        chk("t1_busy", 32'(a_busy), 32'h0);
        out_ready = 1'b1;
        step(1'b0, 1'b0, 2'b00, 1'b0);
        chk("t1_drain", 32'(a_valid), 32'h0);

        // 2: enable every third cycle, noise on idle cycles
        pulse_reset();
        for (int k = 0; k < W; k++) begin
            step(1'b0, 1'b1, 2'b11, 1'b0);
            step(1'b0, 1'b0, 2'b00, 1'b0);
            if (k == W - 1) chk("t2_valid_early", 32'(a_valid), 32'h0);
            send_bits(14'h2A5B, 14'h1234, k == 0, k, k, 1'b0);
        end
        chk("t2_valid", 32'(a_valid), 32'h1);
        chk("t2_data", 32'(a_data), 32'({14'h1234, 14'h2A5B}));
        step(1'b0, 1'b1, 2'b10, 1'b0);
        chk("t2_hold", 32'(a_data), 32'({14'h1234, 14'h2A5B}));

        // 3: continuous back-to-back words with consumer stalled
        pulse_reset();
        send_bits(14'h2A5B, 14'h1234, 1'b1, 0, 13, 1'b0);
        chk("t3_valid1", 32'(b_valid), 32'h1);
        chk("t3_ovr0", 32'(b_ovr), 32'h0);
        send_bits(14'h0F0F, 14'h3333, 1'b0, 0, 13, 1'b0);
        chk("t3_data_kept", 32'(b_data), 32'({14'h1234, 14'h2A5B}));
        chk("t3_ovr", 32'(b_ovr), 32'h1);
        chk("t3_busy", 32'(b_busy), 32'h1);
        step(1'b0, 1'b0, 2'b00, 1'b1);
        chk("t3_ovr_clr", 32'(b_ovr), 32'h0);
        send_bits(14'h0000, 14'h0000, 1'b0, 0, 13, 1'b1);
        chk("t3_set_wins", 32'(b_ovr), 32'h1);
        step(1'b0, 1'b0, 2'b00, 1'b1);
        out_ready = 1'b1;
        step(1'b0, 1'b0, 2'b00, 1'b0);
        chk("t3_drain", 32'(b_valid), 32'h0);
        chk("t3_ovr_clr2", 32'(b_ovr), 32'h0);

        // 4: re-frame at bit 7, then a full all-ones word
        pulse_reset();
        send_bits(14'h2A5B, 14'h1234, 1'b1, 0, 6, 1'b0);
        send_bits(14'h3FFF, 14'h3FFF, 1'b1, 0, 0, 1'b0);
        chk("t4_ferr", 32'(a_ferr), 32'h1);
        chk("t4_no_out", 32'(a_valid), 32'h0);
        send_bits(14'h3FFF, 14'h3FFF, 1'b0, 1, 13, 1'b0);
        chk("t4_valid", 32'(a_valid), 32'h1);
        chk("t4_data", 32'(a_data), 32'({14'h3FFF, 14'h3FFF}));
        out_ready = 1'b1;
        step(1'b0, 1'b0, 2'b00, 1'b1);
        chk("t4_ferr_clr", 32'(a_ferr), 32'h0);
        out_ready = 1'b0;
        // re-frame exactly on the last bit position
        send_bits(14'h1111, 14'h2222, 1'b1, 0, 12, 1'b0);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        chk("t4_last_nocomp", 32'(a_valid), 32'h0);
        chk("t4_last_ferr", 32'(a_ferr), 32'h1);
        chk("t4_last_busy", 32'(a_busy), 32'h1);

        // 5: LSB-first, serial 1 then 13 zeros
        pulse_reset();
        send_bits(14'h2000, 14'h2000, 1'b1, 0, 13, 1'b0);
        chk("t5_lsb_data", 32'(c_data), 32'({14'h0001, 14'h0001}));
        chk("t5_lsb_valid", 32'(c_valid), 32'h1);
        chk("t5_msb_data", 32'(a_data), 32'({14'h2000, 14'h2000}));

        // 6: async reset mid-word with a held output
        pulse_reset();
        send_bits(14'h2A5B, 14'h1234, 1'b1, 0, 13, 1'b0);
        send_bits(14'h0F0F, 14'h3333, 1'b1, 0, 4, 1'b0);
        chk("t6_pre_busy", 32'(a_busy), 32'h1);
        chk("t6_pre_valid", 32'(a_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t6_data", 32'(a_data), 32'h0);
        chk("t6_valid", 32'(a_valid), 32'h0);
        chk("t6_busy", 32'(a_busy), 32'h0);
        chk("t6_ovr", 32'(a_ovr), 32'h0);
        chk("t6_ferr", 32'(a_ferr), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 2'b11, 1'b0);
        chk("t6_idle", 32'(a_busy), 32'h0);
        send_bits(14'h0F0F, 14'h3333, 1'b1, 0, 13, 1'b0);
        chk("t6_recap_valid", 32'(a_valid), 32'h1);
        chk("t6_recap_data", 32'(a_data), 32'({14'h3333, 14'h0F0F}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
